// File: rtl/mem_lsu_port.sv
// MEM-stage load/store port: captures one load/store, runs a req/gnt/rvalid
// handshake with variable-latency data memory and stalls the pipeline meanwhile.
module mem_lsu_port #(
    parameter int ADDR_W      = 32,
    parameter bit ALIGN_CHECK = 1'b1,
    parameter bit FWD_EN      = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sext,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata_orig,
    input  logic [31:0]       wb_back,
    input  logic              fwd_sel,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              adel,
    output logic              ades,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              misaligned_s;
    logic              exc_s;
    logic [1:0]        offset_s;
    logic [3:0]        be_s;
    logic [31:0]       store_data_s;
    logic [31:0]       wdata_s;
    logic              we_r;
    logic [1:0]        size_r;
    logic              sext_r;
    logic [1:0]        off_r;
    logic              rsp_valid_r;
    logic [31:0]       rsp_rdata_r;
    logic              adel_r;
    logic              ades_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [3:0]        mem_be_r;
    logic [31:0]       mem_wdata_r;

    // Bring the addressed lane down to bit 0 and extend it to 32 bits.
    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] off,
                                                input logic [1:0] size, input logic sext);
        logic [31:0] sh;
        logic [31:0] res;
        sh = raw >> {off, 3'b000};
        case (size)
            2'd0:    res = {{24{sext & sh[7]}}, sh[7:0]};
            2'd1:    res = {{16{sext & sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    // Per-size alignment, lane offset and byte enables of the incoming request.
    always_comb begin
        misaligned_s = 1'b0;
        offset_s     = 2'b00;
        be_s         = 4'b1111;
        case (req_size)
            2'd0: begin
                misaligned_s = 1'b0;
                offset_s     = req_addr[1:0];
                be_s         = 4'b0001 << req_addr[1:0];
            end
            2'd1: begin
                misaligned_s = req_addr[0];
                offset_s     = {req_addr[1], 1'b0};
                be_s         = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                misaligned_s = (req_addr[1:0] != 2'b00);
                offset_s     = 2'b00;
                be_s         = 4'b1111;
            end
        endcase
    end

    // Offsets are masked per size above, so with the check disabled the stray bits just drop out.
    assign exc_s        = ALIGN_CHECK && misaligned_s;
    assign store_data_s = (FWD_EN && fwd_sel) ? wb_back : req_wdata_orig;
    assign wdata_s      = store_data_s << {offset_s, 3'b000};

    // Next-state decode; handshake inputs only matter in REQ and WAIT.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_next_s = exc_s ? RESP : REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_next_s = we_r ? RESP : WAIT;
                end else begin
                    state_next_s = REQ;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request capture, memory-side outputs and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_r        <= 1'b0;
            size_r      <= 2'd0;
            sext_r      <= 1'b0;
            off_r       <= 2'd0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0;
            adel_r      <= 1'b0;
            ades_r      <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'h0;
        end else begin
            rsp_valid_r <= (state_next_s == RESP);
            rsp_rdata_r <= 32'h0;
            adel_r      <= 1'b0;
            ades_r      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        we_r   <= req_we;
                        size_r <= req_size;
                        sext_r <= req_sext;
                        off_r  <= offset_s;
                        if (exc_s) begin
                            adel_r <= ~req_we;
                            ades_r <= req_we;
                        end else begin
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= req_we;
                            mem_addr_r  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_be_r    <= be_s;
                            mem_wdata_r <= req_we ? wdata_s : 32'h0;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req_r   <= 1'b0;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= '0;
                        mem_be_r    <= 4'b0000;
                        mem_wdata_r <= 32'h0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        rsp_rdata_r <= extend_load(mem_rdata, off_r, size_r, sext_r);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall     = req_valid & (state_r != RESP);
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign adel      = adel_r;
    assign ades      = ades_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_be    = mem_be_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_lsu_port.sv
// Randomized scoreboard bench for mem_lsu_port against a byte-array memory model,
// with a second instance built without the alignment check.
module tb_mem_lsu_port;

    typedef struct {
        logic [31:0] rdata;
        logic        adel;
        logic        ades;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_sext, fwd_sel;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata_orig, wb_back;
    logic        stall, rsp_valid, adel, ades, mem_req, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    logic        d2_valid, d2_we, d2_sext, d2_fwd;
    logic [1:0]  d2_size;
    logic [31:0] d2_addr, d2_orig, d2_wb;
    logic        d2_stall, d2_rsp_valid, d2_adel, d2_ades, d2_mem_req, d2_mem_we;
    logic [31:0] d2_rsp_rdata, d2_mem_addr, d2_mem_wdata;
    logic [3:0]  d2_mem_be;
    logic        d2_gnt, d2_rvalid;
    logic [31:0] d2_rdata;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb_q[$];
    logic [7:0]  ref_mem[0:255];
    logic [31:0] resp_mem[0:63];
    int          gnt_cfg = 0;
    int          rv_cfg  = 0;
    int          gnt_cnt = 0;
    int          rv_cnt  = 0;
    bit          seen    = 1'b0;
    bit          pend_rd = 1'b0;
    logic [31:0] pend_data;

    mem_lsu_port dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata_orig(req_wdata_orig), .wb_back(wb_back), .fwd_sel(fwd_sel),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .adel(adel),
        .ades(ades), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    mem_lsu_port #(.ALIGN_CHECK(1'b0)) dut2 (
        .clk(clk), .reset(reset), .req_valid(d2_valid), .req_we(d2_we),
        .req_size(d2_size), .req_sext(d2_sext), .req_addr(d2_addr),
        .req_wdata_orig(d2_orig), .wb_back(d2_wb), .fwd_sel(d2_fwd),
        .stall(d2_stall), .rsp_valid(d2_rsp_valid), .rsp_rdata(d2_rsp_rdata),
        .adel(d2_adel), .ades(d2_ades), .mem_req(d2_mem_req), .mem_we(d2_mem_we),
        .mem_addr(d2_mem_addr), .mem_be(d2_mem_be), .mem_wdata(d2_mem_wdata),
        .mem_gnt(d2_gnt), .mem_rvalid(d2_rvalid), .mem_rdata(d2_rdata)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] w);
        resp_mem[idx] = w;
        for (int b = 0; b < 4; b++) ref_mem[4*idx+b] = w[8*b +: 8];
    endtask

    // Data memory with configurable grant and read-data delays.
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (pend_rd) begin
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1; mem_rdata = pend_data; pend_rd = 1'b0;
                end else rv_cnt--;
            end else if (mem_req === 1'b1) begin
                if (!seen) begin seen = 1'b1; gnt_cnt = gnt_cfg; end
                if (gnt_cnt == 0) begin
                    mem_gnt = 1'b1; seen = 1'b0;
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b]) resp_mem[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                    end else begin
                        pend_rd = 1'b1; pend_data = resp_mem[mem_addr[7:2]]; rv_cnt = rv_cfg;
                    end
                end else gnt_cnt--;
            end
        end
    end

    // Scoreboard monitor: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%h expected no response", rsp_rdata);
            end else begin
                e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("adel", 32'(adel), 32'(e.adel));
                check("ades", 32'(ades), 32'(e.ades));
            end
        end
    end

    // One access through dut: reference result queued, handshake and timing checked.
    task automatic do_access(input logic we, input logic [1:0] size, input logic sext,
                             input logic [31:0] addr, input logic [31:0] orig, input logic [31:0] wb,
                             input logic fwd, input int gd, input int rd);
        int nb, off, base, n, n_stall, req_cyc, exp_n;
        bit mis;
        logic [31:0] data, exp_wdata;
        logic [63:0] v, mask, sh;
        logic [7:0]  be8;
        exp_t e;
        nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis  = (addr % nb) != 0;
        off  = int'(addr % 4);
        base = int'(addr - 32'h1000);
        data = fwd ? wb : orig;
        e.rdata = 32'h0; e.adel = 1'b0; e.ades = 1'b0;
        if (mis) begin
            e.adel = ~we; e.ades = we;
        end else if (we) begin
            for (int k = 0; k < nb; k++) begin
                sh = {32'h0, data} >> (8*k);
                ref_mem[base+k] = sh[7:0];
            end
        end else begin
            v = 64'h0;
            for (int k = 0; k < nb; k++) v = v | ({56'h0, ref_mem[base+k]} << (8*k));
            mask = (64'd1 << (8*nb)) - 64'd1;
            if (sext && v[8*nb-1]) v = v | ~mask;
            e.rdata = v[31:0];
        end
        be8       = ((8'd1 << nb) - 8'd1) << off;
        sh        = {32'h0, data} << (8*off);
        exp_wdata = sh[31:0];
        exp_n     = mis ? 1 : (we ? 2 + gd : 3 + gd + rd);
        sb_q.push_back(e);
        gnt_cfg = gd; rv_cfg = rd;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = size; req_sext = sext; req_addr = addr;
        req_wdata_orig = orig; wb_back = wb; fwd_sel = fwd;
        n = 0; n_stall = 0; req_cyc = 0;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) break;
            if (stall === 1'b1) n_stall++;
            if (mem_req === 1'b1) begin
                req_cyc++;
                check("mem_addr", mem_addr, addr & ~32'h3);
                check("mem_be", 32'(mem_be), 32'(be8[3:0]));
                check("mem_we", 32'(mem_we), 32'(we));
                if (we) check("mem_wdata", mem_wdata, exp_wdata);
            end
            n++;
            if (n > 60) begin
                n_cmp++; n_bad++;
                $display("FAIL rsp_timeout: got no rsp_valid in %0d cycles expected %0d", n, exp_n);
                break;
            end
        end
        check("latency", 32'(n), 32'(exp_n));
        check("stall_cycles", 32'(n_stall), 32'(exp_n));
        check("stall_in_resp", 32'(stall), 32'h0);
        check("mem_req_cycles", 32'(req_cyc), mis ? 32'h0 : 32'(gd + 1));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Main stimulus.
    initial begin
        int rsp_seen, req_seen;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sext = 1'b0;
        req_addr = 32'h0; req_wdata_orig = 32'h0; wb_back = 32'h0; fwd_sel = 1'b0;
        d2_valid = 1'b0; d2_we = 1'b0; d2_size = 2'd0; d2_sext = 1'b0; d2_addr = 32'h0;
        d2_orig = 32'h0; d2_wb = 32'h0; d2_fwd = 1'b0; d2_gnt = 1'b0; d2_rvalid = 1'b0;
        d2_rdata = 32'h0;
        for (int i = 0; i < 64; i++) set_word(i, $urandom);
        repeat (3) @(posedge clk);
        #1 req_valid = 1'b1;
        @(negedge clk);
        check("reset_stall_follows_valid", 32'(stall), 32'h1);
        check("reset_ctrl_outputs", {26'h0, rsp_valid, adel, ades, mem_req, mem_we, 1'b0}, 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_mem_be_addr", {mem_be, mem_addr[27:0]}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("idle_no_valid_stall", 32'(stall), 32'h0);

        set_word(1, 32'h8765_4321);
        do_access(1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, 32'h0, 1'b0, 0, 0);
        set_word(0, 32'h80FF_0000);
        do_access(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h0, 1'b0, 0, 0);
        do_access(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h0, 1'b0, 0, 0);
        do_access(1'b1, 2'd1, 1'b0, 32'h1002, 32'h0000_BEEF, 32'h1234_5678, 1'b1, 0, 0);
        do_access(1'b0, 2'd1, 1'b1, 32'h1002, 32'h0, 32'h0, 1'b0, 0, 0);
        do_access(1'b1, 2'd2, 1'b0, 32'h1001, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 0);
        do_access(1'b0, 2'd1, 1'b1, 32'h1005, 32'h0, 32'h0, 1'b0, 0, 0);
        do_access(1'b0, 2'd3, 1'b0, 32'h1008, 32'h0, 32'h0, 1'b0, 3, 2);
        do_access(1'b1, 2'd2, 1'b0, 32'h100C, 32'hA5A5_0F0F, 32'h0, 1'b0, 3, 0);

        // Reset while waiting for read data; the late rvalid must be ignored.
        gnt_cfg = 0; rv_cfg = 5;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h1010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_ctrl", {27'h0, rsp_valid, adel, ades, mem_req, stall}, 32'h0);
        check("post_reset_rdata", rsp_rdata, 32'h0);
        rsp_seen = 0; req_seen = 0;
        repeat (9) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) rsp_seen++;
            if (mem_req === 1'b1) req_seen++;
        end
        check("stale_rvalid_rsp", 32'(rsp_seen), 32'h0);
        check("stale_rvalid_req", 32'(req_seen), 32'h0);
        do_access(1'b0, 2'd2, 1'b0, 32'h1010, 32'h0, 32'h0, 1'b0, 1, 1);

        for (int i = 0; i < 80; i++) begin
            do_access(1'($urandom), 2'($urandom), 1'($urandom), 32'h1000 + ($urandom % 256),
                      $urandom, $urandom, 1'($urandom), int'($urandom % 3), int'($urandom % 3));
        end

        // Alignment check disabled: low address bits are dropped per size.
        @(posedge clk); #1;
        d2_valid = 1'b1; d2_we = 1'b1; d2_size = 2'd2; d2_addr = 32'h1001;
        d2_orig = 32'hCAFE_F00D; d2_gnt = 1'b1; d2_rvalid = 1'b1; d2_rdata = 32'hABCD_1234;
        @(negedge clk);
        check("d2_stall", 32'(d2_stall), 32'h1);
        @(negedge clk);
        check("d2_mem_req", 32'(d2_mem_req), 32'h1);
        check("d2_mem_be", 32'(d2_mem_be), 32'hF);
        check("d2_mem_addr", d2_mem_addr, 32'h1000);
        check("d2_mem_wdata", d2_mem_wdata, 32'hCAFE_F00D);
        @(negedge clk);
        check("d2_store_rsp", {30'h0, d2_rsp_valid, d2_ades}, 32'h2);
        @(posedge clk); #1;
        d2_we = 1'b0; d2_size = 2'd1; d2_sext = 1'b0; d2_addr = 32'h1003;
        @(negedge clk);
        @(negedge clk);
        check("d2_half_be", 32'(d2_mem_be), 32'hC);
        @(negedge clk);
        @(negedge clk);
        check("d2_load_rsp", {30'h0, d2_rsp_valid, d2_adel}, 32'h2);
        check("d2_load_rdata", d2_rsp_rdata, 32'h0000_ABCD);
        @(posedge clk); #1;
        d2_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
